// File: rtl/ddr_sample_reader.sv
// ddr_sample_reader
// Streams a stored audio clip out of DDR3 through the MIG app interface.
// It delivers the clip one 16-bit sample at a time to the sound-output stage.
// Read commands are issued under credit-based flow control. Each returned
// 256-bit word is buffered in a small FIFO and then unpacked into 16 samples,
// low half-word first, one sample per sample_req.
//
// Ports:
//   ui_clk              single clock, rising edge
//   sys_rst             asynchronous active-low reset
//   init_calib_complete MIG calibration done; gates command issue only
//   start               one-cycle pulse that begins playback (ignored while busy)
//   loop                1 = repeat the clip endlessly (sampled continuously)
//   busy                playback in progress (state != IDLE)
//   app_en/app_cmd/app_addr  MIG read command (app_cmd is always read)
//   app_rdy             MIG accepts the command when high together with app_en
//   app_rd_data/app_rd_data_valid  MIG read return
//   sample_req          one-cycle request for the next sample
//   sample_out/sample_valid  registered sample, one cycle after sample_req
//   underrun            sticky: a request arrived with nothing buffered
`timescale 1ns/1ps

module ddr_sample_reader #(
   parameter int                ADDR_W     = 29,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
   parameter int                NUM_WORDS  = 1024,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              ui_clk,
   input  logic              sys_rst,
   input  logic              init_calib_complete,
   input  logic              start,
   input  logic              loop,
   output logic              busy,
   output logic              app_en,
   output logic [2:0]        app_cmd,
   output logic [ADDR_W-1:0] app_addr,
   input  logic              app_rdy,
   input  logic [255:0]      app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              sample_req,
   output logic [15:0]       sample_out,
   output logic              sample_valid,
   output logic              underrun
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int WC_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [WC_W-1:0]   LAST_WORD_C = WC_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP_C = ADDR_W'(8);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t              state_r;
   logic [255:0]        fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    fifo_count_r;
   logic [CNT_W-1:0]    outstanding_r;
   logic [WC_W-1:0]     issued_cnt_r;
   logic [WC_W-1:0]     consumed_cnt_r;
   logic [3:0]          unpack_idx_r;
   logic                app_en_r;
   logic [ADDR_W-1:0]   app_addr_r;
   logic [15:0]         sample_out_r;
   logic                sample_valid_r;
   logic                underrun_r;

   logic                active_s;
   logic                accept_s;
   logic                push_s;
   logic                have_data_s;
   logic                deliver_s;
   logic                pop_s;
   logic [CNT_W-1:0]    fifo_count_nxt_s;
   logic [CNT_W-1:0]    outstanding_nxt_s;
   logic                credit_s;
   logic                last_issue_s;
   logic                drain_done_s;
   logic [15:0]         head_sample_s;

   // Per-cycle handshake decode and next-cycle occupancy used by the credit check.
   always_comb begin
      active_s          = (state_r != ST_IDLE);
      accept_s          = app_en_r & app_rdy;
      // Returns landing in IDLE belong to an aborted run and are dropped.
      push_s            = app_rd_data_valid & active_s;
      have_data_s       = (fifo_count_r != {CNT_W{1'b0}});
      deliver_s         = sample_req & active_s & have_data_s;
      pop_s             = deliver_s & (unpack_idx_r == 4'd15);
      fifo_count_nxt_s  = fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      outstanding_nxt_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(push_s);
      // Buffered plus in-flight words must leave room for one more word.
      credit_s          = ({1'b0, fifo_count_nxt_s} + {1'b0, outstanding_nxt_s})
                          < {1'b0, DEPTH_C};
      last_issue_s      = accept_s & (issued_cnt_r == LAST_WORD_C);
      drain_done_s      = (outstanding_r == {CNT_W{1'b0}}) &&
                          (fifo_count_r == {CNT_W{1'b0}}) &&
                          (unpack_idx_r == 4'd0) &&
                          (consumed_cnt_r == {WC_W{1'b0}});
      head_sample_s     = fifo_mem_r[rd_ptr_r][{unpack_idx_r, 4'b0000} +: 16];
   end

   // Read-data storage; the control block owns pointers and occupancy.
   always_ff @(posedge ui_clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= app_rd_data;
      end
   end

   // Playback FSM together with the command, FIFO-control and sample registers.
   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_r        <= ST_IDLE;
         wr_ptr_r       <= {PTR_W{1'b0}};
         rd_ptr_r       <= {PTR_W{1'b0}};
         fifo_count_r   <= {CNT_W{1'b0}};
         outstanding_r  <= {CNT_W{1'b0}};
         issued_cnt_r   <= {WC_W{1'b0}};
         consumed_cnt_r <= {WC_W{1'b0}};
         unpack_idx_r   <= 4'd0;
         app_en_r       <= 1'b0;
         app_addr_r     <= BASE_ADDR;
         sample_out_r   <= 16'd0;
         sample_valid_r <= 1'b0;
         underrun_r     <= 1'b0;
      end else begin
         // Every request is answered next cycle; no data means a zero sample.
         sample_valid_r <= sample_req;
         if (deliver_s) begin
            sample_out_r <= head_sample_s;
            unpack_idx_r <= unpack_idx_r + 4'd1;
         end else begin
            sample_out_r <= 16'd0;
         end
         if (sample_req && active_s && !have_data_s) begin
            underrun_r <= 1'b1;
         end

         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            if (consumed_cnt_r == LAST_WORD_C) begin
               consumed_cnt_r <= {WC_W{1'b0}};
            end else begin
               consumed_cnt_r <= consumed_cnt_r + WC_W'(1);
            end
         end
         fifo_count_r  <= fifo_count_nxt_s;
         outstanding_r <= outstanding_nxt_s;

         if (accept_s) begin
            app_addr_r   <= app_addr_r + ADDR_STEP_C;
            issued_cnt_r <= issued_cnt_r + WC_W'(1);
         end

         case (state_r)
            ST_IDLE: begin
               wr_ptr_r       <= {PTR_W{1'b0}};
               rd_ptr_r       <= {PTR_W{1'b0}};
               fifo_count_r   <= {CNT_W{1'b0}};
               outstanding_r  <= {CNT_W{1'b0}};
               issued_cnt_r   <= {WC_W{1'b0}};
               consumed_cnt_r <= {WC_W{1'b0}};
               unpack_idx_r   <= 4'd0;
               app_addr_r     <= BASE_ADDR;
               if (start) begin
                  // The buffer is empty here, so only calibration gates the first read.
                  state_r    <= ST_RUN;
                  underrun_r <= 1'b0;
                  app_en_r   <= init_calib_complete;
               end else begin
                  app_en_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (last_issue_s) begin
                  if (loop) begin
                     app_addr_r   <= BASE_ADDR;
                     issued_cnt_r <= {WC_W{1'b0}};
                     app_en_r     <= init_calib_complete & credit_s;
                  end else begin
                     state_r  <= ST_DRAIN;
                     app_en_r <= 1'b0;
                  end
               end else if (app_en_r && !app_rdy) begin
                  // A pending command is held until the MIG takes it.
                  app_en_r <= 1'b1;
               end else begin
                  app_en_r <= init_calib_complete & credit_s;
               end
            end
            ST_DRAIN: begin
               app_en_r <= 1'b0;
               if (drain_done_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               app_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = (state_r != ST_IDLE);
   assign app_en       = app_en_r;
   assign app_cmd      = 3'b001;
   assign app_addr     = app_addr_r;
   assign sample_out   = sample_out_r;
   assign sample_valid = sample_valid_r;
   assign underrun     = underrun_r;

endmodule

// File: tb/tb_ddr_sample_reader.sv
// Directed bench for ddr_sample_reader. Two instances share one MIG model
// selected by sel: u_dut2 (NUM_WORDS=2) and u_dut3 (NUM_WORDS=3, loop test).
`timescale 1ns/1ps

module tb_ddr_sample_reader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         calib;
   logic         start;
   logic         loop_in;
   logic         app_rdy;
   logic         sample_req;
   logic         sel;
   logic         rd_valid = 1'b0;
   logic [255:0] rd_data = '0;

   logic         busy2, en2, sv2, ur2, busy3, en3, sv3, ur3;
   logic [2:0]   cmd2, cmd3;
   logic [28:0]  addr2, addr3;
   logic [15:0]  so2, so3;

   logic         m_busy, m_en, m_valid, m_ur;
   logic [2:0]   m_cmd;
   logic [28:0]  m_addr;
   logic [15:0]  m_out;

   int total = 0;
   int bad   = 0;

   typedef struct { int due; int k; } rsp_t;
   rsp_t q[$];
   int   addr_q[$];
   int   cyc = 0;
   int   lat = 3;
   int   acc = 0;
   int   outst = 0;
   int   max_outst = 0;
   bit   hold_resp = 1'b0;
   int   total_exp;

   always #5 clk = ~clk;

   ddr_sample_reader #(.ADDR_W(29), .BASE_ADDR(29'd0), .NUM_WORDS(2), .FIFO_DEPTH(4)) u_dut2 (
      .ui_clk(clk), .sys_rst(rst_n), .init_calib_complete(calib),
      .start(start & ~sel), .loop(loop_in), .busy(busy2),
      .app_en(en2), .app_cmd(cmd2), .app_addr(addr2), .app_rdy(app_rdy),
      .app_rd_data(rd_data), .app_rd_data_valid(rd_valid & ~sel),
      .sample_req(sample_req & ~sel), .sample_out(so2), .sample_valid(sv2),
      .underrun(ur2));

   ddr_sample_reader #(.ADDR_W(29), .BASE_ADDR(29'd0), .NUM_WORDS(3), .FIFO_DEPTH(4)) u_dut3 (
      .ui_clk(clk), .sys_rst(rst_n), .init_calib_complete(calib),
      .start(start & sel), .loop(loop_in), .busy(busy3),
      .app_en(en3), .app_cmd(cmd3), .app_addr(addr3), .app_rdy(app_rdy),
      .app_rd_data(rd_data), .app_rd_data_valid(rd_valid & sel),
      .sample_req(sample_req & sel), .sample_out(so3), .sample_valid(sv3),
      .underrun(ur3));

   assign m_busy  = sel ? busy3 : busy2;
   assign m_en    = sel ? en3   : en2;
   assign m_cmd   = sel ? cmd3  : cmd2;
   assign m_addr  = sel ? addr3 : addr2;
   assign m_out   = sel ? so3   : so2;
   assign m_valid = sel ? sv3   : sv2;
   assign m_ur    = sel ? ur3   : ur2;

   // Word k of the clip carries samples 16k .. 16k+15, low half-word first.
   function automatic logic [255:0] mkword(input int k);
      logic [255:0] w;
      w = '0;
      for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'(16*k + j);
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_run();
      acc = 0;
      addr_q.delete();
      max_outst = 0;
   endtask

   task automatic play(input int n, input int modv);
      for (int i = 0; i < n; i++) begin
         sample_req = 1'b1;
         @(negedge clk);
         chk($sformatf("smp_valid%0d", i), m_valid, 1);
         chk($sformatf("smp_val%0d", i), m_out, i % modv);
      end
      sample_req = 1'b0;
   endtask

   // MIG model: accept commands, track credit usage, flag pushes into a full FIFO.
   always @(posedge clk) begin
      if (m_en && app_rdy) begin
         q.push_back('{due: cyc + lat, k: int'(m_addr >> 3)});
         addr_q.push_back(int'(m_addr));
         acc++;
         outst++;
      end
      if (rd_valid) begin
         outst--;
         if (m_busy) begin
            total++;
            assert ((sel ? int'(u_dut3.fifo_count_r) : int'(u_dut2.fifo_count_r)) < 4) else begin
               bad++;
               $error("FAIL fifo_overflow got=full want=not_full");
            end
         end
      end
      if (outst > max_outst) max_outst = outst;
      cyc++;
   end

   // MIG model: return read data in order once its latency has elapsed.
   always @(negedge clk) begin
      if (!hold_resp && q.size() > 0 && q[0].due <= cyc) begin
         rd_valid = 1'b1;
         rd_data  = mkword(q[0].k);
         q.delete(0);
      end else begin
         rd_valid = 1'b0;
         rd_data  = '0;
      end
   end

   initial begin
      rst_n = 1'b0; calib = 1'b1; start = 1'b0; loop_in = 1'b0;
      app_rdy = 1'b1; sample_req = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", m_busy, 0);  chk("rst_en", m_en, 0);   chk("rst_cmd", m_cmd, 1);
      chk("rst_addr", m_addr, 0);  chk("rst_out", m_out, 0); chk("rst_valid", m_valid, 0);
      chk("rst_ur", m_ur, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // request in IDLE
      sample_req = 1'b1; @(negedge clk); sample_req = 1'b0;
      chk("idle_valid", m_valid, 1); chk("idle_out", m_out, 0); chk("idle_ur", m_ur, 0);

      // basic playback
      lat = 3; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("start_busy", m_busy, 1); chk("start_en", m_en, 1); chk("start_addr", m_addr, 0);
      repeat (12) @(negedge clk);
      chk("basic_acc", acc, 2); chk("basic_a0", addr_q[0], 0); chk("basic_a1", addr_q[1], 8);
      chk("basic_busy_drain", m_busy, 1);
      play(32, 1000);
      @(negedge clk);
      chk("basic_busy_end", m_busy, 0); chk("basic_ur", m_ur, 0);

      // backpressure
      app_rdy = 1'b0; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_en%0d", i), m_en, 1);
         chk($sformatf("bp_addr%0d", i), m_addr, 0);
         @(negedge clk);
      end
      chk("bp_none", acc, 0);
      app_rdy = 1'b1; @(negedge clk);
      chk("bp_one", acc, 1); chk("bp_addr_next", m_addr, 8); chk("bp_en_next", m_en, 1);
      repeat (10) @(negedge clk);
      chk("bp_acc", acc, 2);
      play(32, 1000);
      @(negedge clk);
      chk("bp_busy_end", m_busy, 0);

      // underrun
      lat = 40; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      @(negedge clk);
      sample_req = 1'b1; @(negedge clk); sample_req = 1'b0;
      chk("ur_valid", m_valid, 1); chk("ur_out", m_out, 0); chk("ur_flag", m_ur, 1);
      repeat (60) @(negedge clk);
      chk("ur_sticky", m_ur, 1);
      play(32, 1000);
      @(negedge clk);
      chk("ur_busy_end", m_busy, 0); chk("ur_after", m_ur, 1);

      // restart clears underrun, then reset with two reads outstanding
      hold_resp = 1'b1; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("ur_clear", m_ur, 0);
      repeat (5) @(negedge clk);
      chk("rm_outst", outst, 2);
      rst_n = 1'b0; #1;
      chk("rm_busy", m_busy, 0);  chk("rm_en", m_en, 0);   chk("rm_cmd", m_cmd, 1);
      chk("rm_addr", m_addr, 0);  chk("rm_out", m_out, 0); chk("rm_valid", m_valid, 0);
      chk("rm_ur", m_ur, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < q.size(); j++) q[j].due = 0;
      hold_resp = 1'b0;
      repeat (6) @(negedge clk);
      chk("rm_delivered", outst, 0);
      chk("rm_fifo", u_dut2.fifo_count_r, 0);
      sample_req = 1'b1; @(negedge clk); sample_req = 1'b0;
      chk("rm_req_valid", m_valid, 1); chk("rm_req_out", m_out, 0);
      chk("rm_req_ur", m_ur, 0); chk("rm_req_busy", m_busy, 0);

      // loop wrap on the 3-word instance
      sel = 1'b1; lat = 20; loop_in = 1'b1; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      chk("lp_credit", acc, 4); chk("lp_busy0", m_busy, 1);
      total_exp = 0;
      for (int i = 0; (total_exp == 0 || i < total_exp) && i < 2000; i++) begin
         if (i >= 120 && loop_in && (acc % 3) == 1) begin
            loop_in   = 1'b0;
            total_exp = (acc + 2) * 16;
         end
         sample_req = 1'b1;
         @(negedge clk);
         chk($sformatf("lp_valid%0d", i), m_valid, 1);
         chk($sformatf("lp_val%0d", i), m_out, i % 48);
         if (loop_in) chk($sformatf("lp_busy%0d", i), m_busy, 1);
      end
      sample_req = 1'b0;
      chk("lp_dropped", (total_exp != 0), 1);
      @(negedge clk);
      chk("lp_busy_end", m_busy, 0);
      chk("lp_words", acc * 16, total_exp);
      chk("lp_ur", m_ur, 0);
      chk("lp_max_outst", max_outst, 4);
      for (int j = 0; j < addr_q.size(); j++) chk($sformatf("lp_addr%0d", j), addr_q[j], (j % 3) * 8);

      // calibration gating
      sel = 1'b0; calib = 1'b0; lat = 3; clear_run();
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("cal_busy", m_busy, 1); chk("cal_en0", m_en, 0);
      repeat (5) @(negedge clk);
      chk("cal_en1", m_en, 0); chk("cal_acc", acc, 0);
      calib = 1'b1; @(negedge clk);
      chk("cal_en_rise", m_en, 1); chk("cal_addr", m_addr, 0);
      repeat (12) @(negedge clk);
      play(32, 1000);
      @(negedge clk);
      chk("cal_busy_end", m_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr_sample_reader.md
# ddr_sample_reader

Streams a stored audio clip out of DDR3 through the MIG user (app) interface and delivers it one 16-bit sample at a time to the sound-output stage. It sits directly downstream of the MIG controller, on the `ui_clk` domain. It issues read commands with credit-based flow control, buffers returned 256-bit words in a small FIFO, and unpacks each word into 16 samples on demand from a sample-rate request strobe.

## Interface
Parameters:
- `ADDR_W`, 29, width of `app_addr`
- `BASE_ADDR`, 0, app address of the first clip word (multiple of 8)
- `NUM_WORDS`, 1024, clip length in 256-bit words (≥1)
- `FIFO_DEPTH`, 4, read-data buffer depth in words (power of 2, ≥2)

Ports:
- `ui_clk` in 1: the single clock; all logic is on its rising edge.
- `sys_rst` in 1: reset, asynchronous, active-low.
- `init_calib_complete` in 1: MIG calibration done.
- `start` in 1: one-cycle pulse that begins playback.
- `loop` in 1: when 1, the clip repeats endlessly; sampled continuously.
- `busy` out 1: playback in progress.
- `app_en` out 1: MIG command valid.
- `app_cmd` out 3: constant 3'b001 (read).
- `app_addr` out ADDR_W: read address.
- `app_rdy` in 1: MIG command accepted this cycle when high with `app_en`.
- `app_rd_data` in 256: read data.
- `app_rd_data_valid` in 1: read data valid.
- `sample_req` in 1: one-cycle request for the next sample.
- `sample_out` out 16: sample value.
- `sample_valid` out 1: one-cycle strobe qualifying `sample_out`.
- `underrun` out 1: sticky; a request arrived with no data buffered.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `start` → RUN.
  - Clears `underrun`, issued-count, consumed-count, FIFO and unpack index.
  - Sets the address to BASE_ADDR.
  - Read data arriving in IDLE is discarded.
- **RUN**
  - Issues reads only while `init_calib_complete`=1 and `fifo_count + outstanding < FIFO_DEPTH`.
  - `outstanding` = commands accepted minus words returned.
  - A command is accepted on a cycle with `app_en && app_rdy`. On acceptance: `app_addr += 8`, issued-count +1, outstanding +1.
  - `app_en` stays high and `app_addr` stays stable until the command is accepted. `app_en` never drops while a command is pending.
  - When issued-count reaches NUM_WORDS:
    - If `loop`=1: address → BASE_ADDR, issued-count → 0, remain in RUN.
    - Else: → DRAIN.
- **DRAIN**
  - No new commands; `app_en`=0.
  - When outstanding=0, FIFO empty and the unpack index is idle (last sample of the last word delivered) → IDLE.
- **Data path**
  - `app_rd_data_valid` pushes `app_rd_data` into the FIFO; outstanding −1.
  - The credit scheme guarantees no overflow. A push into a full FIFO is a design error and must be flagged by a bench assertion.
- **Unpack**
  - The head word yields samples in the order `[15:0]`, `[31:16]`, … `[255:240]`.
  - The FIFO pops when sample 15 of the head word is delivered.
- **`sample_req`**
  - In RUN/DRAIN with data available: output the next sample.
  - In RUN/DRAIN with the FIFO empty: `sample_out`=0, `sample_valid`=1, `underrun`←1. The unpack index does not advance.
  - In IDLE: `sample_out`=0, `sample_valid`=1, no underrun.
- **Other rules**
  - `start` while `busy`=1 is ignored.
  - `busy` = (state ≠ IDLE).
  - Push and pop in the same cycle are both honoured; the FIFO count is unchanged.
  - Calibration low in RUN stalls issue only. Samples already buffered still play.

## Timing
- Reset values: `busy`=0, `app_en`=0, `app_cmd`=3'b001, `app_addr`=BASE_ADDR, `sample_out`=0, `sample_valid`=0, `underrun`=0; state IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. MIG responses arriving afterwards land in IDLE and are discarded.
- `start` at cycle N → `busy`=1 at N+1, first `app_en`=1 at N+1 if calibrated.
- `sample_req` at cycle N → `sample_out`/`sample_valid` registered at N+1.
- Back-to-back `sample_req` on every cycle is supported.
- Read data pushed at cycle N can be consumed by a `sample_req` at N+1.
- Address arithmetic is modulo 2^ADDR_W. Issued-count and consumed-count are sized for NUM_WORDS.

## Test plan
- **Basic playback:** NUM_WORDS=2, `loop`=0; MIG model returns word k holding samples 16k..16k+15; pulse `start`, then 32 `sample_req`.
  - Reads issued to addresses 0 and 8.
  - `sample_out` = 0..31 in order.
  - `busy` falls after the 32nd sample; `underrun`=0.
- **Backpressure:** `app_rdy` held low for 10 cycles while `app_en`=1.
  - `app_en`/`app_addr` stay constant.
  - Exactly one command is accepted when `app_rdy` rises.
  - Outstanding never exceeds FIFO_DEPTH=4.
- **Underrun:** MIG read latency 40 cycles; `sample_req` 2 cycles after `start`.
  - `sample_out`=0 with `sample_valid`=1; `underrun`=1 and stays 1.
  - Later samples are correct.
  - The next `start` clears `underrun`.
- **Loop wrap:** NUM_WORDS=3, `loop`=1.
  - Address sequence 0, 8, 16, 0, 8…
  - Samples repeat 0..47 continuously; `busy` stays 1.
  - Dropping `loop` finishes the current pass, then `busy`=0.
- **Reset mid-run:** assert `sys_rst`=0 with 2 reads outstanding, release, then deliver those 2 responses.
  - All outputs at reset values.
  - The FIFO stays empty; `sample_req` yields 0 with no `underrun`.
- **Calibration gating:** `start` with `init_calib_complete`=0.
  - `busy`=1 but `app_en`=0 until calibration rises.
  - First command to BASE_ADDR one cycle after it rises.
